mux4_scan_ctrl: RTL and testbench

Select sequencer and capture stage for the 4:1 behavioural mux (inputs a, b, c, d; selects s0, s1; output out). Drives s1/s0 through channels 0..3, holds each select for DWELL cycles so the mux output settles, and samples the mux output on the last cycle of each dwell. It assembles the four samples into a 4-bit frame with a one-cycle valid pulse. Supports single-shot and continuous scan, with a graceful stop.

---
 rtl/mux4_scan_ctrl.sv | 119 +++++++++++
 tb/tb_mux4_scan_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_scan_ctrl.sv
// Select sequencer and capture stage for a 4:1 mux: steps the selects through
// channels 0..3, samples the mux output at the end of each dwell and emits 4-bit frames.
module mux4_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid
);

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t           r_state, w_state_n;
  logic [1:0]       r_ch, w_ch_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [2:0]       r_shadow, w_shadow_n;
  logic             r_cont_q, w_cont_q_n;
  logic             r_stop_q, w_stop_q_n;
  logic [3:0]       r_frame, w_frame_n;
  logic             r_frame_valid, w_frame_valid_n;
  logic             w_last;

  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ch          <= '0;
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_cont_q      <= 1'b0;
      r_stop_q      <= 1'b0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_ch          <= w_ch_n;
      r_cnt         <= w_cnt_n;
      r_shadow      <= w_shadow_n;
      r_cont_q      <= w_cont_q_n;
      r_stop_q      <= w_stop_q_n;
      r_frame       <= w_frame_n;
      r_frame_valid <= w_frame_valid_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_ch_n          = r_ch;
    w_cnt_n         = r_cnt;
    w_shadow_n      = r_shadow;
    w_cont_q_n      = r_cont_q;
    w_stop_q_n      = r_stop_q;
    w_frame_n       = r_frame;
    w_frame_valid_n = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_n  = ST_SCAN;
          w_ch_n     = '0;
          w_cnt_n    = '0;
          w_cont_q_n = cont;
          w_stop_q_n = 1'b0;
        end
      end

      ST_SCAN: begin
        w_stop_q_n = r_stop_q | stop;
        w_cnt_n    = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_cnt_n = '0;
          if (r_ch != 2'd3) begin
            case (r_ch)
              2'd0:    w_shadow_n[0] = mux_out;
              2'd1:    w_shadow_n[1] = mux_out;
              default: w_shadow_n[2] = mux_out;
            endcase
            w_ch_n = r_ch + 2'd1;
          end else begin
            w_frame_n       = {mux_out, r_shadow};
            w_frame_valid_n = 1'b1;
            w_ch_n          = '0;
            // A stop arriving on this very edge must also end the scan.
            if (!(r_cont_q && !r_stop_q && !stop)) begin
              w_state_n  = ST_IDLE;
              w_stop_q_n = 1'b0;
              w_cont_q_n = 1'b0;
            end
          end
        end
      end

      default: w_state_n = ST_IDLE;
    endcase
  end

  // ch is forced to 0 whenever the scan ends, so the selects read 00 in IDLE.
  assign s0          = r_ch[0];
  assign s1          = r_ch[1];
  assign busy        = (r_state == ST_SCAN);
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl: DWELL=4 instance u_dut and DWELL=1 instance u_dut1,
// each driving a behavioural 4:1 mux model.
module tb_mux4_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start, cont, stop;
  logic [3:0] in0;
  logic       mux0;
  logic       s0, s1, busy, frame_valid;
  logic [3:0] frame;

  logic       start1, cont1, stop1;
  logic [3:0] in1;
  logic       mux1;
  logic       s0_1, s1_1, busy1, fv1;
  logic [3:0] frame1;

  int n_chk;
  int n_fail;

  mux4_scan_ctrl #(.DWELL(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
    .mux_out(mux0), .s0(s0), .s1(s1), .busy(busy), .frame(frame),
    .frame_valid(frame_valid)
  );

  mux4_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .stop(stop1),
    .mux_out(mux1), .s0(s0_1), .s1(s1_1), .busy(busy1), .frame(frame1),
    .frame_valid(fv1)
  );

  // Behavioural 4:1 muxes, inputs packed {d,c,b,a}
  assign mux0 = in0[{s1, s0}];
  assign mux1 = in1[{s1_1, s0_1}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_scan(input logic c);
    @(negedge clk);
    start = 1'b1;
    cont  = c;
    @(negedge clk);
    start = 1'b0;
    cont  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({s1, s0, busy, frame, frame_valid} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_u0 got %b exp 00000000", {s1, s0, busy, frame, frame_valid});
    end
    n_chk++;
    if ({s1_1, s0_1, busy1, frame1, fv1} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_u1 got %b exp 00000000", {s1_1, s0_1, busy1, frame1, fv1});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release fv=%b busy=%b exp 0 0", frame_valid, busy);
    end
  endtask

  task automatic test_single();
    logic [1:0] exp_sel;
    in0 = 4'b1010;
    start_scan(1'b0);
    for (int j = 0; j < 16; j++) begin
      exp_sel = 2'(j / 4);
      n_chk++;
      if ({s1, s0} !== exp_sel || busy !== 1'b1 || frame_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_scan t=%0d sel=%b busy=%b fv=%b exp sel=%b busy=1 fv=0",
                 j, {s1, s0}, busy, frame_valid, exp_sel);
      end
      @(negedge clk);
    end
    n_chk++;
    if (frame_valid !== 1'b1 || frame !== 4'b1010 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done fv=%b frame=%b busy=%b sel=%b exp 1 1010 0 00",
               frame_valid, frame, busy, {s1, s0});
    end
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b0 || frame !== 4'b1010 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold fv=%b frame=%b busy=%b exp 0 1010 0", frame_valid, frame, busy);
    end
  endtask

  task automatic test_continuous();
    logic exp_fv, exp_busy;
    int   pulses;
    pulses = 0;
    in0 = 4'b1010;
    start_scan(1'b1);
    for (int t = 0; t <= 60; t++) begin
      exp_fv   = (t == 16) || (t == 32);
      exp_busy = (t < 32);
      if (frame_valid === 1'b1) pulses++;
      n_chk++;
      if (frame_valid !== exp_fv || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL cont_cycle t=%0d fv=%b busy=%b exp fv=%b busy=%b",
                 t, frame_valid, busy, exp_fv, exp_busy);
      end
      if (t == 16) begin
        n_chk++;
        if (frame !== 4'b1010) begin
          n_fail++;
          $display("FAIL cont_frame1 got %b exp 1010", frame);
        end
        in0[3] = 1'b0;
      end
      if (t == 32) begin
        n_chk++;
        if (frame !== 4'b0010) begin
          n_fail++;
          $display("FAIL cont_frame2 got %b exp 0010", frame);
        end
      end
      if (t == 20) stop = 1'b1;
      if (t == 21) stop = 1'b0;
      @(negedge clk);
    end
    n_chk++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL cont_pulses got %0d exp 2", pulses);
    end
  endtask

  task automatic test_start_ignored();
    int pulses;
    pulses = 0;
    in0 = 4'b1010;
    start_scan(1'b0);
    for (int t = 0; t <= 40; t++) begin
      if (frame_valid === 1'b1) pulses++;
      if (t == 3 || t == 9) begin
        start = 1'b1;
        cont  = 1'b1;
      end else begin
        start = 1'b0;
        cont  = 1'b0;
      end
      @(negedge clk);
    end
    n_chk++;
    if (pulses != 1 || busy !== 1'b0 || frame !== 4'b1010) begin
      n_fail++;
      $display("FAIL start_ignored pulses=%0d busy=%b frame=%b exp 1 0 1010", pulses, busy, frame);
    end
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    pulses = 0;
    in0 = 4'b1010;
    start_scan(1'b0);
    repeat (9) @(negedge clk);
    n_chk++;
    if ({s1, s0} !== 2'b10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_pre sel=%b busy=%b exp 10 1", {s1, s0}, busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s1, s0, busy, frame, frame_valid} !== 8'd0) begin
      n_fail++;
      $display("FAIL midscan_async got %b exp 00000000", {s1, s0, busy, frame, frame_valid});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (frame_valid === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    n_chk++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midscan_quiet got %0d active cycles exp 0", pulses);
    end
    in0 = 4'b0011;
    start_scan(1'b0);
    repeat (16) @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b1 || frame !== 4'b0011 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_fresh fv=%b frame=%b busy=%b exp 1 0011 0", frame_valid, frame, busy);
    end
  endtask

  task automatic test_back_to_back();
    in0 = 4'b0110;
    start_scan(1'b0);
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end fv=%b busy=%b exp 1 0", frame_valid, busy);
    end
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || {s1, s0} !== 2'b00 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart busy=%b sel=%b fv=%b exp 1 00 0", busy, {s1, s0}, frame_valid);
    end
    repeat (16) @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b1 || frame !== 4'b0110 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second fv=%b frame=%b busy=%b exp 1 0110 0", frame_valid, frame, busy);
    end
  endtask

  task automatic test_stop_final_edge();
    in0 = 4'b1001;
    start_scan(1'b1);
    repeat (15) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || {s1, s0} !== 2'b11) begin
      n_fail++;
      $display("FAIL stopfinal_pre busy=%b sel=%b exp 1 11", busy, {s1, s0});
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_chk++;
    if (frame_valid !== 1'b1 || frame !== 4'b1001 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
      n_fail++;
      $display("FAIL stopfinal_end fv=%b frame=%b busy=%b sel=%b exp 1 1001 0 00",
               frame_valid, frame, busy, {s1, s0});
    end
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stopfinal_after fv=%b busy=%b exp 0 0", frame_valid, busy);
    end
  endtask

  task automatic test_dwell1();
    // Input pattern presented before each sample edge; samples give frame 0101.
    logic [3:0] pat [4];
    pat[0] = 4'b0001;
    pat[1] = 4'b1101;
    pat[2] = 4'b0100;
    pat[3] = 4'b0011;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_chk++;
      if ({s1_1, s0_1} !== 2'(j) || busy1 !== 1'b1 || fv1 !== 1'b0) begin
        n_fail++;
        $display("FAIL dwell1_sel t=%0d sel=%b busy=%b fv=%b exp sel=%b busy=1 fv=0",
                 j, {s1_1, s0_1}, busy1, fv1, 2'(j));
      end
      in1 = pat[j];
      @(negedge clk);
    end
    n_chk++;
    if (fv1 !== 1'b1 || frame1 !== 4'b0101 || busy1 !== 1'b0 || {s1_1, s0_1} !== 2'b00) begin
      n_fail++;
      $display("FAIL dwell1_frame fv=%b frame=%b busy=%b sel=%b exp 1 0101 0 00",
               fv1, frame1, busy1, {s1_1, s0_1});
    end
    @(negedge clk);
    n_chk++;
    if (fv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL dwell1_pulse fv=%b exp 0", fv1);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    cont   = 1'b0;
    stop   = 1'b0;
    in0    = 4'b0000;
    start1 = 1'b0;
    cont1  = 1'b0;
    stop1  = 1'b0;
    in1    = 4'b0000;
    test_reset();
    test_single();
    test_continuous();
    test_start_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    test_stop_final_edge();
    test_dwell1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
